// File: rtl/exec_pkg.sv
// Shared definitions for the R-type execute stage: SPECIAL func codes, FSM states
// and the muldiv operation descriptor.
package exec_pkg;

    localparam int EXEC_WIDTH = 32;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } exec_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_op_t;

endpackage

// File: rtl/execute_unit_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock.
// Works on magnitudes; signs are applied in the fixup cycle, which is the only time HI/LO change.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int WIDTH = EXEC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             iter_i,
    input  logic             fixup_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_t             op_q, op_d;
    logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, divz_q, divz_d;

    logic [WIDTH-1:0]   rs_mag, rt_mag, quot, rem;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign last_o = iter_i && (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_comb begin
        rs_mag    = (op_i.is_signed && rs_i[WIDTH-1]) ? -rs_i : rs_i;
        rt_mag    = (op_i.is_signed && rt_i[WIDTH-1]) ? -rt_i : rt_i;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        prod      = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot      = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        rs_raw_d = rs_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        divz_d   = divz_q;

        if (start_i) begin
            // Dividend / multiplier sit in the low half; the other operand is held in opnd.
            acc_d    = {{WIDTH{1'b0}}, op_i.is_div ? rs_mag : rt_mag};
            opnd_d   = op_i.is_div ? rt_mag : rs_mag;
            rs_raw_d = rs_i;
            cnt_d    = '0;
            op_d     = op_i;
            neg_a_d  = op_i.is_signed && rs_i[WIDTH-1];
            neg_b_d  = op_i.is_signed && rt_i[WIDTH-1];
            divz_d   = (rt_i == '0);
        end else if (iter_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!op_q.is_div) begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (fixup_i) begin
            if (!op_q.is_div) begin
                {hi_d, lo_d} = prod;
            end else if (divz_q) begin
                hi_d = rs_raw_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quot;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            rs_raw_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rs_raw_q <= rs_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            divz_q   <= divz_d;
        end
    end

endmodule

// File: rtl/execute_unit.sv
// R-type execute stage: single-cycle ALU, IDLE/ITER/FIXUP control FSM and registered outputs.
// Handshake: an operation is taken on a clock edge where in_valid && in_ready; results appear as a one-cycle out_valid pulse.
module execute_unit
    import exec_pkg::*;
#(
    parameter int   WIDTH         = EXEC_WIDTH,
    parameter bit   ENABLE_MULDIV = 1'b1,
    localparam int  SHAMT_W       = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic [SHAMT_W-1:0] sa,
    input  logic [5:0]         func,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_out,
    output logic               wb_en,
    output logic               overflow,
    output logic               unimpl,
    output exec_state_e        state_dbg
);
    exec_state_e      state_q, state_d;
    logic             accept, md_start, md_iter, md_fixup, md_last;
    md_op_t           md_op;
    logic [WIDTH-1:0] hi, lo;

    logic [WIDTH-1:0] alu_res, add_res, sub_res;
    logic             alu_wb, alu_ovf, alu_un, add_ovf, sub_ovf;
    logic [SHAMT_W-1:0] var_amt;

    logic             out_valid_q, out_valid_d, wb_en_q, wb_en_d;
    logic             overflow_q, overflow_d, unimpl_q, unimpl_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign accept       = in_valid && in_ready;
    assign md_op.is_div    = func[1];
    assign md_op.is_signed = !func[0];

    always_comb begin
        add_res  = rs + rt;
        sub_res  = rs - rt;
        add_ovf  = (rs[WIDTH-1] == rt[WIDTH-1]) && (add_res[WIDTH-1] != rs[WIDTH-1]);
        sub_ovf  = (rs[WIDTH-1] != rt[WIDTH-1]) && (sub_res[WIDTH-1] != rs[WIDTH-1]);
        var_amt  = rs[SHAMT_W-1:0];
        alu_res  = '0;
        alu_wb   = 1'b1;
        alu_ovf  = 1'b0;
        alu_un   = 1'b0;
        md_start = 1'b0;
        case (func)
            FN_ADD:   if (add_ovf) begin alu_wb = 1'b0; alu_ovf = 1'b1; end else alu_res = add_res;
            FN_SUB:   if (sub_ovf) begin alu_wb = 1'b0; alu_ovf = 1'b1; end else alu_res = sub_res;
            FN_ADDU:  alu_res = add_res;
            FN_SUBU:  alu_res = sub_res;
            FN_AND:   alu_res = rs & rt;
            FN_OR:    alu_res = rs | rt;
            FN_XOR:   alu_res = rs ^ rt;
            FN_NOR:   alu_res = ~(rs | rt);
            FN_SLT:   alu_res = WIDTH'($signed(rs) < $signed(rt));
            FN_SLTU:  alu_res = WIDTH'(rs < rt);
            FN_SLL:   alu_res = rt << sa;
            FN_SRL:   alu_res = rt >> sa;
            FN_SRA:   alu_res = $signed(rt) >>> sa;
            FN_SLLV:  alu_res = rt << var_amt;
            FN_SRLV:  alu_res = rt >> var_amt;
            FN_SRAV:  alu_res = $signed(rt) >>> var_amt;
            FN_MFHI, FN_MFLO: begin
                if (ENABLE_MULDIV) alu_res = (func == FN_MFHI) ? hi : lo;
                else begin alu_wb = 1'b0; alu_un = 1'b1; end
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                if (ENABLE_MULDIV) md_start = 1'b1;
                else begin alu_wb = 1'b0; alu_un = 1'b1; end
            end
            default: begin
                alu_wb = 1'b0;
                alu_un = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && md_start) state_d = ITER;
            ITER:    if (md_last) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        md_iter   = (state_q == ITER);
        md_fixup  = (state_q == FIXUP);
        state_dbg = state_q;
    end

    generate
        if (ENABLE_MULDIV) begin : g_muldiv
            muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
                .clk_i   (clock),
                .rst_ni  (reset_n),
                .start_i (accept && md_start),
                .op_i    (md_op),
                .rs_i    (rs),
                .rt_i    (rt),
                .iter_i  (md_iter),
                .fixup_i (md_fixup),
                .last_o  (md_last),
                .hi_o    (hi),
                .lo_o    (lo)
            );
        end else begin : g_no_muldiv
            assign md_last = 1'b0;
            assign hi      = '0;
            assign lo      = '0;
        end
    endgenerate

    // Muldiv completion carries no writeback; data_out stays zero unless wb_en is set.
    always_comb begin
        out_valid_d = 1'b0;
        data_d      = '0;
        wb_en_d     = 1'b0;
        overflow_d  = 1'b0;
        unimpl_d    = 1'b0;
        if (md_fixup) begin
            out_valid_d = 1'b1;
        end else if (accept && !md_start) begin
            out_valid_d = 1'b1;
            data_d      = alu_wb ? alu_res : '0;
            wb_en_d     = alu_wb;
            overflow_d  = alu_ovf;
            unimpl_d    = alu_un;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            wb_en_q     <= 1'b0;
            overflow_q  <= 1'b0;
            unimpl_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            wb_en_q     <= wb_en_d;
            overflow_q  <= overflow_d;
            unimpl_q    <= unimpl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign wb_en     = wb_en_q;
    assign overflow  = overflow_q;
    assign unimpl    = unimpl_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: ALU ops, overflow, shifts, compares, unimplemented funcs,
// MULT/DIV latency and results via MFHI/MFLO, and asynchronous reset during an iteration.
module tb_execute_unit;
    import exec_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [4:0]  sa = '0;
    logic [5:0]  func = '0;
    logic        out_valid;
    logic [31:0] data_out;
    logic        wb_en;
    logic        overflow;
    logic        unimpl;
    exec_state_e state_dbg;

    int total = 0;
    int bad   = 0;

    execute_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .sa        (sa),
        .func      (func),
        .out_valid (out_valid),
        .data_out  (data_out),
        .wb_en     (wb_en),
        .overflow  (overflow),
        .unimpl    (unimpl),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s);
        in_valid = 1'b1;
        func     = f;
        rs       = a;
        rt       = b;
        sa       = s;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic wb,
                              input logic ov, input logic un);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, data_out, d);
        chk({tag, "_wb"}, 32'(wb_en), 32'(wb));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
        chk({tag, "_unimpl"}, 32'(unimpl), 32'(un));
    endtask

    task automatic single(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] s, input logic [31:0] d,
                          input logic wb, input logic ov, input logic un);
        @(negedge clock);
        drive(f, a, b, s);
        @(negedge clock);
        in_valid = 1'b0;
        expect_out(tag, d, wb, ov, un);
    endtask

    // Expects the completion pulse on the 34th sample after the accepting edge, busy until then.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        int  n;
        logic ready_low;
        @(negedge clock);
        drive(f, a, b, 5'd0);
        n = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            n++;
            if (!out_valid && in_ready) ready_low = 1'b0;
        end while (!out_valid && n < 100);
        chk({tag, "_latency"}, 32'(n), 32'd34);
        chk({tag, "_busy"}, 32'(ready_low), 32'd1);
        expect_out(tag, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_wb", 32'(wb_en), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        reset_n = 1'b1;
        single("mfhi_rst", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Add/sub and overflow
        single("add_zero", FN_ADD, 32'h7, 32'hFFFF_FFF9, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        single("add_ovf", FN_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        single("addu_wrap", FN_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        single("sub_ovf", FN_SUB, 32'h8000_0000, 32'h1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        single("sub_ok", FN_SUB, 32'h5, 32'h9, 5'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        single("subu_wrap", FN_SUBU, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Logic
        single("and", FN_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b1, 1'b0, 1'b0);
        single("or", FN_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b1, 1'b0, 1'b0);
        single("xor", FN_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b1, 1'b0, 1'b0);
        single("nor", FN_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 1'b1, 1'b0, 1'b0);

        // Shifts and compares
        single("srav", FN_SRAV, 32'h0000_0024, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
        single("sll", FN_SLL, 32'hFFFF_FFFF, 32'h1, 5'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        single("srl", FN_SRL, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b1, 1'b0, 1'b0);
        single("sra", FN_SRA, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
        single("sllv", FN_SLLV, 32'h0000_0021, 32'h3, 5'd7, 32'h6, 1'b1, 1'b0, 1'b0);
        single("srlv", FN_SRLV, 32'h0000_003C, 32'hF000_0000, 5'd0, 32'hF, 1'b1, 1'b0, 1'b0);
        single("slt", FN_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b1, 1'b0, 1'b0);
        single("sltu", FN_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Unimplemented funcs
        single("jr", FN_JR, 32'h1234, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        single("jalr", FN_JALR, 32'h1234, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        single("fn3f", 6'b111111, 32'h1, 32'h2, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Back-to-back accepts, then the pulse must drop
        @(negedge clock);
        drive(FN_ADDU, 32'h1, 32'h2, 5'd0);
        @(negedge clock);
        expect_out("b2b_a", 32'h3, 1'b1, 1'b0, 1'b0);
        drive(FN_SUBU, 32'h5, 32'h7, 5'd0);
        @(negedge clock);
        in_valid = 1'b0;
        expect_out("b2b_b", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("b2b_drop", 32'(out_valid), 32'd0);

        // Multiply / divide
        run_md("mult", FN_MULT, 32'hFFFF_FFFE, 32'h3);
        single("mult_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        single("mult_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0);
        run_md("multu", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        single("multu_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        single("multu_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        run_md("div", FN_DIV, 32'h7, 32'hFFFF_FFFE);
        single("div_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        single("div_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'h1, 1'b1, 1'b0, 1'b0);
        run_md("divn", FN_DIV, 32'hFFFF_FFF9, 32'h2);
        single("divn_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
        single("divn_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_md("divu0", FN_DIVU, 32'h5, 32'h0);
        single("divu0_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        single("divu0_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'h5, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a MULT
        @(negedge clock);
        drive(FN_MULT, 32'h3, 32'h5, 5'd0);
        @(negedge clock);
        in_valid = 1'b0;
        chk("mid_busy", 32'(in_ready), 32'd0);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        chk("mid_no_pulse", 32'(seen), 32'd0);
        single("mid_lo", FN_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        single("mid_hi", FN_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
